ccg_exhaustive_sig: RTL and testbench

CCG_EXHAUSTIVE_SIG -- requirements
Module: ccg_exhaustive_sig

---
 rtl/ccg_exhaustive_sig.sv | 105 ++++++++++
 tb/tb_ccg_exhaustive_sig.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccg_exhaustive_sig.sv
// Exhaustive pattern sweep over a combinational benchmark with MISR compaction.
// Patterns go out in binary or Gray order; responses are folded in LAT cycles later.
module ccg_exhaustive_sig #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 20,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             gray_i,
  output logic [N_IN-1:0]  pat_o,
  input  logic [N_OUT-1:0] resp_i,
  output logic             busy,
  output logic             done,
  output logic [31:0]      sig_o
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [N_IN-1:0] CNT_LAST = '1;
  localparam logic [2:0]      DR_LAST  = 3'(LAT > 0 ? LAT - 1 : 0);

  state_t          state;
  logic [N_IN-1:0] cnt;
  logic [2:0]      dcnt;
  logic            mode;
  logic [31:0]     sig;
  logic            run, kill, cap, fb;

  assign run  = (state == RUN);
  assign kill = abort && (state == RUN || state == DRAIN);
  assign fb   = sig[31] ^ sig[21] ^ sig[1] ^ sig[0];

  // cap marks the cycle in which resp_i belongs to a pattern issued LAT cycles earlier
  generate
    if (LAT == 0) begin : g_nolat
      assign cap = run;
    end else begin : g_lat
      logic [LAT:1] vld_pipe;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_pipe <= '0;
        end else if (kill) begin
          vld_pipe <= '0;
        end else begin
          vld_pipe[1] <= run;
          for (int i = 2; i <= LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
      end
      assign cap = vld_pipe[LAT];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      dcnt  <= '0;
      mode  <= 1'b0;
      sig   <= '0;
    end else begin
      if (cap && !kill) sig <= {sig[30:0], fb} ^ 32'(resp_i);
      case (state)
        IDLE, DONE: begin
          if (start && !abort) begin
            state <= RUN;
            cnt   <= '0;
            mode  <= gray_i;
            sig   <= 32'hFFFF_FFFF;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            state <= (LAT == 0) ? DONE : DRAIN;
            dcnt  <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (abort)                 state <= IDLE;
          else if (dcnt == DR_LAST)  state <= DONE;
          else                       dcnt  <= dcnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    pat_o = '0;
    if (run) pat_o = mode ? (cnt ^ (cnt >> 1)) : cnt;
  end

  assign busy  = (state == RUN) || (state == DRAIN);
  assign done  = (state == DONE);
  assign sig_o = sig;

endmodule

// File: tb/tb_ccg_exhaustive_sig.sv
// Bench for ccg_exhaustive_sig: several parameter sets, per-cycle scoreboard of
// expected busy/done/pat_o/sig_o against a software pattern and MISR model.
module tb_ccg_exhaustive_sig;

  localparam int NU = 5;
  localparam int NI [NU] = '{4, 1, 4, 3, 4};
  localparam int LT [NU] = '{1, 0, 2, 3, 3};

  typedef struct {
    logic        busy;
    logic        done;
    logic [15:0] pat;
    logic        chk_sig;
    logic [31:0] sig;
  } exp_t;

  logic        clk, rst;
  logic        start [NU];
  logic        abort_s [NU];
  logic        gray [NU];
  logic        resp_en [NU];
  logic [15:0] pat [NU];
  logic        busy [NU];
  logic        done [NU];
  logic [31:0] sig [NU];

  int checks = 0;
  int errors = 0;
  exp_t exp_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] rsp_fn(input logic [15:0] p);
    logic [31:0] r;
    r = (32'(p) * 32'h0000_9E37) ^ (32'(p) << 11) ^ 32'h0000_05A5;
    return r[19:0];
  endfunction

  function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [19:0] r);
    logic f;
    f = s[31] ^ s[21] ^ s[1] ^ s[0];
    return {s[30:0], f} ^ 32'(r);
  endfunction

  function automatic logic [15:0] pat_of(input int i, input logic g);
    logic [15:0] v;
    v = 16'(i);
    return g ? (v ^ (v >> 1)) : v;
  endfunction

  for (genvar g = 0; g < NU; g++) begin : gi
    logic [NI[g]-1:0] p;
    logic [19:0]      rsp;
    logic [19:0]      dl [8];
    assign pat[g] = 16'(p);
    always @(posedge clk) begin
      dl[0] <= rsp_fn(16'(p));
      for (int i = 1; i < 8; i++) dl[i] <= dl[i-1];
    end
    if (LT[g] == 0) begin : g_d0
      assign rsp = resp_en[g] ? rsp_fn(16'(p)) : 20'h0;
    end else begin : g_dn
      assign rsp = resp_en[g] ? dl[LT[g]-1] : 20'h0;
    end
    ccg_exhaustive_sig #(.N_IN(NI[g]), .N_OUT(20), .LAT(LT[g])) u_dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start[g]),
      .abort  (abort_s[g]),
      .gray_i (gray[g]),
      .pat_o  (p),
      .resp_i (rsp),
      .busy   (busy[g]),
      .done   (done[g]),
      .sig_o  (sig[g])
    );
  end

  // Runs nsw sweeps on unit k with start held until the last sweep has been accepted.
  task automatic sweep(input int k, input logic g, input int nsw, input logic tog);
    int n, l, per, idx;
    logic [31:0] m;
    exp_t e;
    n = 1 << NI[k];
    l = LT[k];
    per = n + l + 1;
    for (int s = 0; s < nsw; s++) begin
      m = 32'hFFFF_FFFF;
      for (int i = 0; i < n; i++) begin
        m = misr_step(m, resp_en[k] ? rsp_fn(pat_of(i, g)) : 20'h0);
        exp_q.push_back('{1'b1, 1'b0, pat_of(i, g), 1'b0, 32'h0});
      end
      for (int d = 0; d < l; d++) exp_q.push_back('{1'b1, 1'b0, 16'h0, 1'b0, 32'h0});
      exp_q.push_back('{1'b0, 1'b1, 16'h0, 1'b1, m});
    end
    gray[k] = g;
    start[k] = 1'b1;
    idx = 0;
    m = 32'h0;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      if (idx >= (nsw - 1) * per) start[k] = 1'b0;
      if (tog) gray[k] = ~gray[k];
      checks++;
      if (busy[k] !== e.busy || done[k] !== e.done || pat[k] !== e.pat) begin
        errors++;
        $display("FAIL u%0d cyc%0d busy/done/pat got %b/%b/%h want %b/%b/%h",
                 k, idx, busy[k], done[k], pat[k], e.busy, e.done, e.pat);
      end
      if (e.chk_sig) begin
        m = e.sig;
        checks++;
        if (sig[k] !== e.sig) begin
          errors++;
          $display("FAIL u%0d sig_at_done got %h want %h", k, sig[k], e.sig);
        end
      end
      idx++;
    end
    gray[k] = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (busy[k] !== 1'b0 || done[k] !== 1'b0 || sig[k] !== m) begin
        errors++;
        $display("FAIL u%0d idle_hold busy/done/sig got %b/%b/%h want 0/0/%h",
                 k, busy[k], done[k], sig[k], m);
      end
    end
  endtask

  task automatic test_reset;
    for (int k = 0; k < NU; k++) begin
      checks++;
      if (busy[k] !== 1'b0 || done[k] !== 1'b0 || pat[k] !== 16'h0 || sig[k] !== 32'h0) begin
        errors++;
        $display("FAIL u%0d reset busy/done/pat/sig got %b/%b/%h/%h want 0/0/0/0",
                 k, busy[k], done[k], pat[k], sig[k]);
      end
    end
  endtask

  task automatic test_binary_sweep;
    sweep(0, 1'b0, 1, 1'b0);
  endtask

  task automatic test_min_sig;
    sweep(1, 1'b0, 1, 1'b0);
    checks++;
    if (sig[1] !== 32'hFFFF_FFFD) begin
      errors++;
      $display("FAIL min_sig got %h want FFFFFFFD", sig[1]);
    end
  endtask

  task automatic test_gray;
    sweep(3, 1'b1, 1, 1'b1);
    sweep(0, 1'b1, 1, 1'b1);
  endtask

  task automatic test_back_to_back;
    sweep(2, 1'b0, 2, 1'b0);
  endtask

  task automatic test_abort;
    logic [31:0] frz;
    bit hit;
    hit = 0;
    start[4] = 1'b1;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(posedge clk); #1;
      start[4] = 1'b0;
      if (pat[4] == 16'd5) begin
        abort_s[4] = 1'b1;
        hit = 1;
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL abort_reach_pat5 got none want 5");
    end
    @(posedge clk); #1;
    abort_s[4] = 1'b0;
    checks++;
    if (busy[4] !== 1'b0 || pat[4] !== 16'h0 || done[4] !== 1'b0) begin
      errors++;
      $display("FAIL abort_next busy/pat/done got %b/%h/%b want 0/0/0", busy[4], pat[4], done[4]);
    end
    frz = sig[4];
    repeat (10) begin
      @(posedge clk); #1;
      checks++;
      if (done[4] !== 1'b0 || sig[4] !== frz) begin
        errors++;
        $display("FAIL abort_frozen done/sig got %b/%h want 0/%h", done[4], sig[4], frz);
      end
    end
  endtask

  task automatic test_abort_priority;
    start[0] = 1'b1;
    abort_s[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    abort_s[0] = 1'b0;
    repeat (3) begin
      checks++;
      if (busy[0] !== 1'b0 || pat[0] !== 16'h0) begin
        errors++;
        $display("FAIL abort_prio busy/pat got %b/%h want 0/0", busy[0], pat[0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_async_reset;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    checks++;
    if (busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_busy got %b want 1", busy[0]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (busy[0] !== 1'b0 || pat[0] !== 16'h0 || done[0] !== 1'b0 || sig[0] !== 32'h0) begin
      errors++;
      $display("FAIL async_reset busy/pat/done/sig got %b/%h/%b/%h want 0/0/0/0",
               busy[0], pat[0], done[0], sig[0]);
    end
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (done[0] !== 1'b0 || busy[0] !== 1'b0) begin
        errors++;
        $display("FAIL held_reset done/busy got %b/%b want 0/0", done[0], busy[0]);
      end
    end
    rst = 1'b0;
    sweep(0, 1'b0, 1, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < NU; k++) begin
      start[k] = 1'b0;
      abort_s[k] = 1'b0;
      gray[k] = 1'b0;
      resp_en[k] = (k != 1);
    end
    #2;
    test_reset;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_binary_sweep;
    test_min_sig;
    test_gray;
    test_back_to_back;
    test_abort;
    test_abort_priority;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
